// File: rtl/mcpu_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control unit: state codes,
// opcode/funct values, ALU and mux-select codes, and the per-state output table.
package mcpu_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_IF     = 4'd1,
        S_ID     = 4'd2,
        S_EX_R   = 4'd3,
        S_EX_I   = 4'd4,
        S_EX_LS  = 4'd5,
        S_MEM_RD = 4'd6,
        S_MEM_WR = 4'd7,
        S_WB_R   = 4'd8,
        S_WB_I   = 4'd9,
        S_WB_LW  = 4'd10,
        S_EX_BR  = 4'd11,
        S_EX_J   = 4'd12
`ifdef MCTRL_STEP_EN
        , S_WAIT = 4'd13
`endif
    } state_e;

    typedef enum logic [2:0] {
        CLS_R, CLS_I, CLS_LW, CLS_SW, CLS_BEQ, CLS_BNE, CLS_J, CLS_ILL
    } inst_cls_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLLV = 6'h04;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_NOR = 3'b011;
    localparam logic [2:0] ALU_ADD = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;
    localparam logic [2:0] ALU_SLL = 3'b111;

    localparam logic [1:0] PCS_SEQ = 2'b00;
    localparam logic [1:0] PCS_BR  = 2'b01;
    localparam logic [1:0] PCS_JMP = 2'b10;

    localparam logic [1:0] WRS_RD = 2'b00;
    localparam logic [1:0] WRS_RT = 2'b01;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_s;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] w_r_s;
        logic       wr_data_s;
        logic       alu_srcb;
        logic       imm_s;
        logic [2:0] alu_op;
        logic       mem_write;
    } ctrl_out_t;

    // Moore output table; the branch PC_Write term depends on ZF and is added outside.
    function automatic ctrl_out_t ctrl_for(input state_e s, input logic [2:0] alu,
                                           input logic zext);
        ctrl_out_t o;
        o = '0;
        case (s)
            S_IF:     begin o.ir_write = 1'b1; o.pc_write = 1'b1; o.pc_s = PCS_SEQ; end
            S_EX_R:   o.alu_op = alu;
            S_EX_I:   begin o.alu_srcb = 1'b1; o.imm_s = zext; o.alu_op = alu; end
            S_EX_LS,
            S_MEM_RD: begin o.alu_srcb = 1'b1; o.alu_op = ALU_ADD; end
            S_MEM_WR: begin o.alu_srcb = 1'b1; o.alu_op = ALU_ADD; o.mem_write = 1'b1; end
            S_EX_BR:  begin o.alu_op = ALU_SUB; o.pc_s = PCS_BR; end
            S_EX_J:   begin o.pc_write = 1'b1; o.pc_s = PCS_JMP; end
            S_WB_R:   begin o.reg_write = 1'b1; o.w_r_s = WRS_RD; o.alu_op = alu; end
            S_WB_I:   begin
                o.reg_write = 1'b1; o.w_r_s = WRS_RT; o.alu_op = alu; o.alu_srcb = 1'b1;
            end
            S_WB_LW:  begin o.reg_write = 1'b1; o.w_r_s = WRS_RT; o.wr_data_s = 1'b1; end
            default:  ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control-unit <-> datapath bundle. With MCTRL_STEP_EN defined it also carries
// the single-step input.
interface multicycle_ctrl_if;
    logic [31:0] Inst_code;
    logic        ZF;
    logic        PC_Write;
    logic [1:0]  PC_s;
    logic        IR_Write;
    logic        Reg_Write;
    logic [1:0]  w_r_s;
    logic        wr_data_s;
    logic        ALU_SrcB;
    logic        imm_s;
    logic [2:0]  ALU_OP;
    logic        Mem_Write;
    logic        ill_inst;
    logic [3:0]  state;
`ifdef MCTRL_STEP_EN
    logic        step;
`endif

    modport master (
        input  Inst_code, ZF,
`ifdef MCTRL_STEP_EN
        input  step,
`endif
        output PC_Write, PC_s, IR_Write, Reg_Write, w_r_s, wr_data_s,
               ALU_SrcB, imm_s, ALU_OP, Mem_Write, ill_inst, state
    );

    modport slave (
        output Inst_code, ZF,
`ifdef MCTRL_STEP_EN
        output step,
`endif
        input  PC_Write, PC_s, IR_Write, Reg_Write, w_r_s, wr_data_s,
               ALU_SrcB, imm_s, ALU_OP, Mem_Write, ill_inst, state
    );
endinterface

// File: rtl/mcpu_decode.sv
// Combinational instruction decoder: opcode/funct -> class, ALU code,
// zero-extend select and illegal flag. Consulted only while in ID.
module mcpu_decode
    import mcpu_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output inst_cls_e  o_cls,
    output logic [2:0] o_alu_op,
    output logic       o_imm_s,
    output logic       o_illegal
);

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        o_cls    = CLS_ILL;
        o_alu_op = ALU_AND;
        o_imm_s  = 1'b0;
        case (i_opcode)
            OP_RTYPE: begin
                o_cls = CLS_R;
                case (i_funct)
                    FN_ADD:  o_alu_op = ALU_ADD;
                    FN_SUB:  o_alu_op = ALU_SUB;
                    FN_AND:  o_alu_op = ALU_AND;
                    FN_OR:   o_alu_op = ALU_OR;
                    FN_XOR:  o_alu_op = ALU_XOR;
                    FN_NOR:  o_alu_op = ALU_NOR;
                    FN_SLT:  o_alu_op = ALU_SLT;
                    FN_SLLV: o_alu_op = ALU_SLL;
                    default: o_cls = CLS_ILL;
                endcase
            end
            OP_ADDI: begin o_cls = CLS_I; o_alu_op = ALU_ADD; end
            OP_ANDI: begin o_cls = CLS_I; o_alu_op = ALU_AND; o_imm_s = 1'b1; end
            OP_ORI:  begin o_cls = CLS_I; o_alu_op = ALU_OR;  o_imm_s = 1'b1; end
            OP_XORI: begin o_cls = CLS_I; o_alu_op = ALU_XOR; o_imm_s = 1'b1; end
            OP_SLTI: begin o_cls = CLS_I; o_alu_op = ALU_SLT; end
            OP_LW:   begin o_cls = CLS_LW; o_alu_op = ALU_ADD; end
            OP_SW:   begin o_cls = CLS_SW; o_alu_op = ALU_ADD; end
            OP_BEQ:  begin o_cls = CLS_BEQ; o_alu_op = ALU_SUB; end
            OP_BNE:  begin o_cls = CLS_BNE; o_alu_op = ALU_SUB; end
            OP_J:    o_cls = CLS_J;
            default: o_cls = CLS_ILL;
        endcase
    end

    assign o_illegal = (o_cls == CLS_ILL);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset control FSM with registered Moore outputs.
// Define MCTRL_STEP_EN to add the WAIT state and single-step input.
module multicycle_ctrl
    import mcpu_pkg::*;
(
    input  logic               clka,
    input  logic               rst,
    multicycle_ctrl_if.master  bus
);

`ifdef MCTRL_STEP_EN
    localparam state_e S_FETCH_ENTRY = S_WAIT;
`else
    localparam state_e S_FETCH_ENTRY = S_IF;
`endif

    state_e     r_state, w_next;
    inst_cls_e  r_cls, w_cls_next;
    logic [2:0] r_alu, w_alu_next;
    logic       r_imm, w_imm_next;
    logic       r_rel;
    ctrl_out_t  r_out;

    inst_cls_e  w_dec_cls;
    logic [2:0] w_dec_alu;
    logic       w_dec_imm;
    logic       w_dec_ill;
    logic       w_br_take;

    mcpu_decode u_decode (
        .i_opcode  (bus.Inst_code[31:26]),
        .i_funct   (bus.Inst_code[5:0]),
        .o_cls     (w_dec_cls),
        .o_alu_op  (w_dec_alu),
        .o_imm_s   (w_dec_imm),
        .o_illegal (w_dec_ill)
    );

    always_comb begin
        w_next     = r_state;
        w_cls_next = r_cls;
        w_alu_next = r_alu;
        w_imm_next = r_imm;
        case (r_state)
            // r_rel delays the first fetch by one edge after reset release.
            S_IDLE:   if (r_rel) w_next = S_FETCH_ENTRY;
            S_IF:     w_next = S_ID;
            S_ID: begin
                w_cls_next = w_dec_cls;
                w_alu_next = w_dec_alu;
                w_imm_next = w_dec_imm;
                case (w_dec_cls)
                    CLS_R:            w_next = S_EX_R;
                    CLS_I:            w_next = S_EX_I;
                    CLS_LW, CLS_SW:   w_next = S_EX_LS;
                    CLS_BEQ, CLS_BNE: w_next = S_EX_BR;
                    CLS_J:            w_next = S_EX_J;
                    default:          w_next = S_FETCH_ENTRY;
                endcase
            end
            S_EX_R:   w_next = S_WB_R;
            S_EX_I:   w_next = S_WB_I;
            S_EX_LS:  w_next = (r_cls == CLS_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: w_next = S_WB_LW;
            S_WB_R, S_WB_I, S_WB_LW, S_MEM_WR, S_EX_BR, S_EX_J:
                      w_next = S_FETCH_ENTRY;
`ifdef MCTRL_STEP_EN
            S_WAIT:   if (bus.step) w_next = S_IF;
`endif
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cls   <= CLS_ILL;
            r_alu   <= ALU_AND;
            r_imm   <= 1'b0;
            r_rel   <= 1'b0;
            r_out   <= '0;
        end else begin
            // NOTE: non-blocking, so every register here samples pre-edge values.
            r_state <= w_next;
            r_cls   <= w_cls_next;
            r_alu   <= w_alu_next;
            r_imm   <= w_imm_next;
            r_rel   <= 1'b1;
            r_out   <= ctrl_for(w_next, w_alu_next, w_imm_next);
        end
    end

    // ZF is only valid during the compare itself, so the branch enable stays combinational.
    assign w_br_take = (r_state == S_EX_BR) & (bus.ZF ^ (r_cls == CLS_BNE));

    assign bus.PC_Write  = r_out.pc_write | w_br_take;
    assign bus.PC_s      = r_out.pc_s;
    assign bus.IR_Write  = r_out.ir_write;
    assign bus.Reg_Write = r_out.reg_write;
    assign bus.w_r_s     = r_out.w_r_s;
    assign bus.wr_data_s = r_out.wr_data_s;
    assign bus.ALU_SrcB  = r_out.alu_srcb;
    assign bus.imm_s     = r_out.imm_s;
    assign bus.ALU_OP    = r_out.alu_op;
    assign bus.Mem_Write = r_out.mem_write;
    assign bus.ill_inst  = (r_state == S_ID) & w_dec_ill;
    assign bus.state     = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed and random instructions
// compared cycle by cycle against a per-instruction phase model.
module tb_multicycle_ctrl;

    logic clka = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clka (clka),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 clka = ~clka;

    typedef enum {K_R, K_I, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_ILL} kind_e;
    typedef enum {P_IF, P_ID, P_EXR, P_EXI, P_EXLS, P_MEMRD, P_MEMWR,
                  P_WBR, P_WBI, P_WBLW, P_EXBR, P_EXJ} phase_e;
    typedef struct {
        kind_e      kind;
        logic [2:0] alu;
        logic       zext;
    } model_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {ill, PC_Write, PC_s, IR_Write, Reg_Write, w_r_s, wr_data_s, ALU_SrcB, imm_s, ALU_OP, Mem_Write}
    function automatic logic [14:0] obs_out();
        return {bus.ill_inst, bus.PC_Write, bus.PC_s, bus.IR_Write, bus.Reg_Write,
                bus.w_r_s, bus.wr_data_s, bus.ALU_SrcB, bus.imm_s, bus.ALU_OP, bus.Mem_Write};
    endfunction

    function automatic model_t model_decode(input logic [31:0] inst);
        model_t m;
        m.kind = K_ILL; m.alu = 3'd0; m.zext = 1'b0;
        case (inst[31:26])
            6'h00: begin
                m.kind = K_R;
                case (inst[5:0])
                    6'h24: m.alu = 3'd0;
                    6'h25: m.alu = 3'd1;
                    6'h26: m.alu = 3'd2;
                    6'h27: m.alu = 3'd3;
                    6'h20: m.alu = 3'd4;
                    6'h22: m.alu = 3'd5;
                    6'h2A: m.alu = 3'd6;
                    6'h04: m.alu = 3'd7;
                    default: m.kind = K_ILL;
                endcase
            end
            6'h08: begin m.kind = K_I; m.alu = 3'd4; end
            6'h0C: begin m.kind = K_I; m.alu = 3'd0; m.zext = 1'b1; end
            6'h0D: begin m.kind = K_I; m.alu = 3'd1; m.zext = 1'b1; end
            6'h0E: begin m.kind = K_I; m.alu = 3'd2; m.zext = 1'b1; end
            6'h0A: begin m.kind = K_I; m.alu = 3'd6; end
            6'h23: m.kind = K_LW;
            6'h2B: m.kind = K_SW;
            6'h04: m.kind = K_BEQ;
            6'h05: m.kind = K_BNE;
            6'h02: m.kind = K_J;
            default: m.kind = K_ILL;
        endcase
        return m;
    endfunction

    function automatic logic [3:0] exp_state(input phase_e p);
        case (p)
            P_IF: return 4'd1;     P_ID: return 4'd2;     P_EXR: return 4'd3;
            P_EXI: return 4'd4;    P_EXLS: return 4'd5;   P_MEMRD: return 4'd6;
            P_MEMWR: return 4'd7;  P_WBR: return 4'd8;    P_WBI: return 4'd9;
            P_WBLW: return 4'd10;  P_EXBR: return 4'd11;  default: return 4'd12;
        endcase
    endfunction

    function automatic logic [14:0] exp_out(input phase_e p, input model_t m, input logic zf);
        logic ill, pcw, irw, rw, wds, srcb, imm, mw;
        logic [1:0] pcs, wrs;
        logic [2:0] alu;
        {ill, pcw, irw, rw, wds, srcb, imm, mw} = '0;
        pcs = 2'b00; wrs = 2'b00; alu = 3'b000;
        case (p)
            P_IF:    begin irw = 1'b1; pcw = 1'b1; end
            P_ID:    ill = (m.kind == K_ILL);
            P_EXR:   alu = m.alu;
            P_EXI:   begin srcb = 1'b1; imm = m.zext; alu = m.alu; end
            P_EXLS:  begin srcb = 1'b1; alu = 3'b100; end
            P_MEMRD: begin srcb = 1'b1; alu = 3'b100; end
            P_MEMWR: begin srcb = 1'b1; alu = 3'b100; mw = 1'b1; end
            P_WBR:   begin rw = 1'b1; wrs = 2'b00; alu = m.alu; end
            P_WBI:   begin rw = 1'b1; wrs = 2'b01; alu = m.alu; srcb = 1'b1; end
            P_WBLW:  begin rw = 1'b1; wrs = 2'b01; wds = 1'b1; end
            P_EXBR:  begin alu = 3'b101; pcs = 2'b01; pcw = (m.kind == K_BEQ) ? zf : ~zf; end
            P_EXJ:   begin pcw = 1'b1; pcs = 2'b10; end
            default: ;
        endcase
        return {ill, pcw, pcs, irw, rw, wrs, wds, srcb, imm, alu, mw};
    endfunction

    // Walks one instruction from IF; abort_k >= 0 asserts reset during that phase.
    task automatic run_inst(input string name, input logic [31:0] inst,
                            input int zf_force, input int abort_k);
        model_t m;
        phase_e seq[$];
        logic [31:0] rnd;
        logic zf;
        m = model_decode(inst);
        seq = '{P_IF, P_ID};
        case (m.kind)
            K_R:          begin seq.push_back(P_EXR); seq.push_back(P_WBR); end
            K_I:          begin seq.push_back(P_EXI); seq.push_back(P_WBI); end
            K_LW:         begin seq.push_back(P_EXLS); seq.push_back(P_MEMRD); seq.push_back(P_WBLW); end
            K_SW:         begin seq.push_back(P_EXLS); seq.push_back(P_MEMWR); end
            K_BEQ, K_BNE: seq.push_back(P_EXBR);
            K_J:          seq.push_back(P_EXJ);
            default:      ;
        endcase
        foreach (seq[k]) begin
            @(negedge clka);
            rnd = $urandom;
            zf = (zf_force < 0) ? rnd[0] : zf_force[0];
            bus.ZF = zf;
            bus.Inst_code = (seq[k] == P_IF || seq[k] == P_ID) ? inst : $urandom;
            #1;
            check($sformatf("%s %s state", name, seq[k].name()), {28'd0, bus.state},
                  {28'd0, exp_state(seq[k])});
            check($sformatf("%s %s outputs", name, seq[k].name()), {17'd0, obs_out()},
                  {17'd0, exp_out(seq[k], m, zf)});
            if (k == abort_k) begin
                #1 rst = 1'b0;
                #1;
                check($sformatf("%s abort state", name), {28'd0, bus.state}, 32'd0);
                check($sformatf("%s abort outputs", name), {17'd0, obs_out()}, 32'd0);
                return;
            end
        end
    endtask

    task automatic release_reset();
        @(negedge clka);
        #2 rst = 1'b1;
        @(negedge clka);
        #1;
        check("post-release first edge state", {28'd0, bus.state}, 32'd0);
        check("post-release first edge outputs", {17'd0, obs_out()}, 32'd0);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] rnd;
        int pick;
        rnd = $urandom;
        pick = $urandom_range(0, 18);
        case (pick)
            0:  return {6'h00, rnd[25:6], 6'h20};
            1:  return {6'h00, rnd[25:6], 6'h22};
            2:  return {6'h00, rnd[25:6], 6'h24};
            3:  return {6'h00, rnd[25:6], 6'h25};
            4:  return {6'h00, rnd[25:6], 6'h26};
            5:  return {6'h00, rnd[25:6], 6'h27};
            6:  return {6'h00, rnd[25:6], 6'h2A};
            7:  return {6'h00, rnd[25:6], 6'h04};
            8:  return {6'h08, rnd[25:0]};
            9:  return {6'h0C, rnd[25:0]};
            10: return {6'h0D, rnd[25:0]};
            11: return {6'h0E, rnd[25:0]};
            12: return {6'h0A, rnd[25:0]};
            13: return {6'h23, rnd[25:0]};
            14: return {6'h2B, rnd[25:0]};
            15: return {6'h04, rnd[25:0]};
            16: return {6'h05, rnd[25:0]};
            17: return {6'h02, rnd[25:0]};
            default: return rnd[0] ? {6'h3F, rnd[25:0]} : {6'h00, rnd[25:6], 6'h3F};
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        bus.Inst_code = 32'd0;
        bus.ZF = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("async reset state", {28'd0, bus.state}, 32'd0);
        check("async reset outputs", {17'd0, obs_out()}, 32'd0);
        repeat (3) @(negedge clka);
        #1;
        check("held reset state", {28'd0, bus.state}, 32'd0);
        release_reset();

        run_inst("add", 32'h00221820, -1, -1);
        run_inst("lw", 32'h8C050008, -1, -1);
        run_inst("sw", 32'hAC050008, -1, -1);
        run_inst("beq zf1", 32'h10220003, 1, -1);
        run_inst("beq zf0", 32'h10220003, 0, -1);
        run_inst("bne zf1", 32'h14220003, 1, -1);
        run_inst("bne zf0", 32'h14220003, 0, -1);
        run_inst("j", 32'h08000010, -1, -1);
        run_inst("addi", 32'h2025FFFF, -1, -1);
        run_inst("andi", 32'h302500FF, -1, -1);
        run_inst("slti", 32'h28250010, -1, -1);
        run_inst("sllv", 32'h00221804, -1, -1);
        run_inst("ill op3F", 32'hFC000000, -1, -1);
        run_inst("ill funct", 32'h0000003F, -1, -1);
        run_inst("add after ill", 32'h00221820, -1, -1);

        run_inst("add abort", 32'h00221820, -1, 3);
        release_reset();
        run_inst("add restart", 32'h00221820, -1, -1);
        run_inst("lw abort", 32'h8C050008, -1, 4);
        release_reset();

        for (int n = 0; n < 60; n++) begin
            run_inst($sformatf("rand%0d", n), rand_inst(), -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Control unit that sequences the multi-cycle MIPS-subset datapath built around the instruction-fetch stage. It steps each instruction through fetch, decode, execute, memory and write-back states. It drives the write enables and mux selects for PC, IR, register file, ALU and data memory. It sits beside the fetch module on the same clock and reads the latched instruction word back from it.

## Interface
Parameters:
- none; all encodings are package constants.

Ports:
- clka  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- Inst_code  in  32  IR contents from fetch stage; valid from ID onward
- ZF  in  1  ALU zero flag, valid in the same cycle as the ALU operation
- PC_Write  out  1  PC register load enable
- PC_s  out  2  next-PC select: 00 PC+4, 01 branch target, 10 jump target
- IR_Write  out  1  IR load enable
- Reg_Write  out  1  register-file write enable
- w_r_s  out  2  write-register select: 00 rd, 01 rt
- wr_data_s  out  1  write-data select: 0 ALU result, 1 memory data
- ALU_SrcB  out  1  0 rt data, 1 extended immediate
- imm_s  out  1  0 sign-extend, 1 zero-extend
- ALU_OP  out  3  000 and, 001 or, 010 xor, 011 nor, 100 add, 101 sub, 110 slt, 111 sll
- Mem_Write  out  1  data-memory write enable
- ill_inst  out  1  one-cycle pulse in ID on an unsupported opcode or funct
- state  out  4  current state code, for debug and LEDs

## Operation
- States:
  - IDLE
  - IF
  - ID
  - EX_R
  - EX_I
  - EX_LS
  - MEM_RD
  - MEM_WR
  - WB_R
  - WB_I
  - WB_LW
  - EX_BR
  - EX_J
- Transitions:
  - IDLE→IF always.
  - IF→ID always.
  - ID→ by class: R-type→EX_R; addi/andi/ori/xori/slti→EX_I; lw/sw→EX_LS; beq/bne→EX_BR; j→EX_J; illegal→IF.
  - EX_R→WB_R. EX_I→WB_I.
  - EX_LS→MEM_RD for lw, MEM_WR for sw.
  - MEM_RD→WB_LW.
  - WB_*, MEM_WR, EX_BR, EX_J→IF.
- Supported instructions:
  - R-type funct: add 20, sub 22, and 24, or 25, xor 26, nor 27, slt 2A, sllv 04.
  - I-type opcodes: addi 08, andi 0C, ori 0D, xori 0E, slti 0A, lw 23, sw 2B, beq 04, bne 05, j 02.
- Outputs are Moore; they decode from state plus the class and ALU code registered at the end of ID. Unlisted outputs are 0 in each state.
  - IF: IR_Write=1, PC_Write=1, PC_s=00.
  - ID: ill_inst=1 only if illegal.
  - EX_R: ALU_SrcB=0, ALU_OP from funct.
  - EX_I: ALU_SrcB=1; imm_s=1 for andi/ori/xori; ALU_OP from opcode.
  - EX_LS: ALU_SrcB=1, imm_s=0, ALU_OP=100.
  - EX_BR: ALU_SrcB=0, ALU_OP=101; PC_Write=ZF for beq, ~ZF for bne; PC_s=01.
  - EX_J: PC_Write=1, PC_s=10.
  - MEM_WR: Mem_Write=1, ALU_OP=100, ALU_SrcB=1.
  - MEM_RD: ALU_OP=100, ALU_SrcB=1.
  - WB_R: Reg_Write=1, w_r_s=00, wr_data_s=0, ALU_OP and ALU_SrcB held from EX.
  - WB_I: Reg_Write=1, w_r_s=01, wr_data_s=0, ALU_OP and ALU_SrcB held from EX.
  - WB_LW: Reg_Write=1, w_r_s=01, wr_data_s=1.
- Writes to register 0 are issued normally; the register file ignores them.
- An illegal instruction behaves as a 2-cycle nop. PC has already advanced by 4.

## Timing
- Reset asserted (rst=0): state=IDLE immediately, independent of clka. All outputs 0; ALU_OP=000.
- Reset mid-instruction aborts with no further writes. A Mem_Write or Reg_Write high at the moment of assertion drops combinationally.
- First IF occurs on the second rising edge after rst deasserts.
- Cycles per instruction, IF through last state: R/I-type 4, lw 5, sw 4, beq/bne 3, j 3, illegal 2.
- Class and ALU_OP registers load only on the ID→next edge. They hold through the instruction, so Inst_code may change after ID without effect.
- ZF is sampled combinationally in EX_BR. A taken branch loads PC on the EX_BR→IF edge.

## Configuration
- MCTRL_STEP_EN defined:
  - adds input step (1 bit).
  - IDLE and every transition into IF instead go to a WAIT state (code 1101).
  - WAIT holds, all outputs 0, until step=1 is sampled on a rising edge; then IF.
  - step is level-sampled; holding it high runs continuously.
- MCTRL_STEP_EN undefined: no step port, no WAIT state; behaviour exactly as above.

## Structure
- Package mcpu_pkg holds:
  - state codes (4-bit localparams),
  - opcode and funct constants,
  - ALU_OP codes,
  - PC_s and w_r_s encodings.
- One sub-module, mcpu_decode: combinational Inst_code → instruction class, ALU_OP, imm_s, illegal. Used in ID.

## Test plan
- Reset: rst=0 mid-clock → state=0000 (IDLE) and every output 0 without a clock edge. Release → IF on the 2nd edge with IR_Write=1, PC_Write=1.
- add $3,$1,$2 (0x00221820):
  - IF, ID, EX_R (ALU_OP=100, ALU_SrcB=0), WB_R (Reg_Write=1, w_r_s=00).
  - Back in IF on the 5th edge.
- lw $5,8($0) (0x8C050008): 5 states; WB_LW with wr_data_s=1, w_r_s=01. sw: Mem_Write high exactly one cycle.
- beq (0x10220003):
  - ZF=1 → PC_Write=1, PC_s=01 in EX_BR.
  - ZF=0 → PC_Write=0.
  - bne inverts both cases.
- Opcode 0x3F: ill_inst=1 for one cycle in ID, back to IF, no Reg_Write or Mem_Write. Then rst=0 during WB_R → Reg_Write drops immediately.
- With MCTRL_STEP_EN, step=0: parks in WAIT (1101). A single-cycle step pulse advances exactly one instruction.
